// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry layout and ring-offset helper for the reorder buffer
// and its tag CAM.
package reorder_buffer_pkg;

  localparam int DEPTH      = 32;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = PTR_W + 1;
  localparam int PREG_W     = 6;
  localparam int AREG_W     = 5;
  localparam int TAG_W      = 32;
  localparam int DELAY_SLOT = 1;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic [TAG_W-1:0]  instr_num;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              regwr;
  } rob_entry_t;

  // Age of a slot relative to the head, in allocation order.
  function automatic logic [PTR_W-1:0] rob_offset(input logic [PTR_W-1:0] idx,
                                                  input logic [PTR_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/reorder_buffer_tag_cam.sv
// Equality match of one tag against every valid ROB slot. Tags are unique
// among live entries, so the lowest matching index is simply the match.
module rob_tag_cam
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]            tag,
  input  logic [DEPTH-1:0]            entry_valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] entry_tag,
  output logic                        hit,
  output logic [PTR_W-1:0]            idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (tag != '0) && entry_valid[i] && (entry_tag[i] == tag)) begin
        hit = 1'b1;
        idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at dispatch, marks completions from
// EXE and MEM, squashes wrong-path entries on redirect and retires one per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              disp_valid,
  input  logic [TAG_W-1:0]  disp_instr_num,
  input  logic [AREG_W-1:0] disp_areg,
  input  logic [PREG_W-1:0] disp_preg,
  input  logic [PREG_W-1:0] disp_old_preg,
  input  logic              disp_regwr,
  output logic              disp_ready,
  input  logic              exe_complete,
  input  logic [TAG_W-1:0]  exe_instr_num,
  input  logic              mem_complete,
  input  logic [TAG_W-1:0]  mem_instr_num,
  input  logic              redirect_valid,
  input  logic [TAG_W-1:0]  redirect_instr_num,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_instr_num,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic [CNT_W-1:0]  rob_count,
  output logic              rob_empty
);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0]  commit_instr_num_q, commit_instr_num_d;
  logic [AREG_W-1:0] commit_areg_q, commit_areg_d;
  logic [PREG_W-1:0] commit_preg_q, commit_preg_d;
  logic              free_valid_q, free_valid_d;
  logic [PREG_W-1:0] free_preg_q, free_preg_d;

  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0][TAG_W-1:0] tag_vec;
  logic                        exe_hit, mem_hit, redir_hit;
  logic [PTR_W-1:0]            exe_idx, mem_idx, redir_idx;
  logic                        redirecting, do_commit, do_dispatch;
  logic [CNT_W-1:0]            keep_n, keep;
  logic [DEPTH-1:0]            squash;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      tag_vec[i]   = entries_q[i].instr_num;
    end
  end

  rob_tag_cam u_exe_cam (
    .tag(exe_complete ? exe_instr_num : '0), .entry_valid(valid_vec),
    .entry_tag(tag_vec), .hit(exe_hit), .idx(exe_idx));

  rob_tag_cam u_mem_cam (
    .tag(mem_complete ? mem_instr_num : '0), .entry_valid(valid_vec),
    .entry_tag(tag_vec), .hit(mem_hit), .idx(mem_idx));

  rob_tag_cam u_redir_cam (
    .tag(redirect_valid ? redirect_instr_num : '0), .entry_valid(valid_vec),
    .entry_tag(tag_vec), .hit(redir_hit), .idx(redir_idx));

  assign disp_ready = (count_q != CNT_W'(DEPTH)) && !redirect_valid;
  assign rob_empty  = (count_q == '0);

  // Entries survive a redirect only up to the branch plus its delay slot;
  // everything younger is squashed and the tail pulls back to match.
  always_comb begin
    redirecting = redirect_valid && redir_hit;
    keep_n      = CNT_W'(rob_offset(redir_idx, head_q)) + CNT_W'(1 + DELAY_SLOT);
    keep        = count_q;
    if (redirecting && (keep_n < count_q)) keep = keep_n;
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (redirecting && (CNT_W'(rob_offset(PTR_W'(i), head_q)) >= keep)) squash[i] = 1'b1;
    end
  end

  always_comb begin
    entries_d          = entries_q;
    do_commit          = entries_q[head_q].valid && entries_q[head_q].complete;
    do_dispatch        = disp_valid && disp_ready;
    commit_valid_d     = do_commit;
    commit_instr_num_d = '0;
    commit_areg_d      = '0;
    commit_preg_d      = '0;
    free_valid_d       = do_commit && entries_q[head_q].regwr;
    free_preg_d        = '0;
    head_d             = head_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (squash[i]) begin
        entries_d[i].valid    = 1'b0;
        entries_d[i].complete = 1'b0;
      end
    end
    if (exe_hit && !squash[exe_idx]) entries_d[exe_idx].complete = 1'b1;
    if (mem_hit && !squash[mem_idx]) entries_d[mem_idx].complete = 1'b1;

    if (do_commit) begin
      commit_instr_num_d = entries_q[head_q].instr_num;
      commit_areg_d      = entries_q[head_q].areg;
      commit_preg_d      = entries_q[head_q].preg;
      entries_d[head_q]  = '0;
      head_d             = head_q + PTR_W'(1);
    end
    if (free_valid_d) free_preg_d = entries_q[head_q].old_preg;

    if (do_dispatch) begin
      entries_d[tail_q].valid     = 1'b1;
      entries_d[tail_q].complete  = 1'b0;
      entries_d[tail_q].instr_num = disp_instr_num;
      entries_d[tail_q].areg      = disp_areg;
      entries_d[tail_q].preg      = disp_preg;
      entries_d[tail_q].old_preg  = disp_old_preg;
      entries_d[tail_q].regwr     = disp_regwr;
    end

    // A full ring with nothing squashed wraps keep to 0, landing tail on head.
    tail_d  = redirecting ? head_q + keep[PTR_W-1:0] : tail_q + PTR_W'(do_dispatch);
    count_d = keep - CNT_W'(do_commit) + CNT_W'(do_dispatch);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      commit_valid_q     <= 1'b0;
      commit_instr_num_q <= '0;
      commit_areg_q      <= '0;
      commit_preg_q      <= '0;
      free_valid_q       <= 1'b0;
      free_preg_q        <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      commit_valid_q     <= commit_valid_d;
      commit_instr_num_q <= commit_instr_num_d;
      commit_areg_q      <= commit_areg_d;
      commit_preg_q      <= commit_preg_d;
      free_valid_q       <= free_valid_d;
      free_preg_q        <= free_preg_d;
    end
  end

  assign commit_valid     = commit_valid_q;
  assign commit_instr_num = commit_instr_num_q;
  assign commit_areg      = commit_areg_q;
  assign commit_preg      = commit_preg_q;
  assign free_valid       = free_valid_q;
  assign free_preg        = free_preg_q;
  assign rob_count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboarded bench for reorder_buffer: dispatched tags are queued in program
// order and every retirement is matched against the front of the queue.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              disp_valid = 1'b0;
  logic [TAG_W-1:0]  disp_instr_num = '0;
  logic [AREG_W-1:0] disp_areg = '0;
  logic [PREG_W-1:0] disp_preg = '0;
  logic [PREG_W-1:0] disp_old_preg = '0;
  logic              disp_regwr = 1'b0;
  logic              disp_ready;
  logic              exe_complete = 1'b0;
  logic [TAG_W-1:0]  exe_instr_num = '0;
  logic              mem_complete = 1'b0;
  logic [TAG_W-1:0]  mem_instr_num = '0;
  logic              redirect_valid = 1'b0;
  logic [TAG_W-1:0]  redirect_instr_num = '0;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_instr_num;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic [CNT_W-1:0]  rob_count;
  logic              rob_empty;

  int unsigned exp_q[$];
  int num_checks = 0;
  int num_errors = 0;
  bit expect_drop = 1'b0;

  reorder_buffer dut (
    .CLK(CLK), .RESET(RESET),
    .disp_valid(disp_valid), .disp_instr_num(disp_instr_num), .disp_areg(disp_areg),
    .disp_preg(disp_preg), .disp_old_preg(disp_old_preg), .disp_regwr(disp_regwr),
    .disp_ready(disp_ready),
    .exe_complete(exe_complete), .exe_instr_num(exe_instr_num),
    .mem_complete(mem_complete), .mem_instr_num(mem_instr_num),
    .redirect_valid(redirect_valid), .redirect_instr_num(redirect_instr_num),
    .commit_valid(commit_valid), .commit_instr_num(commit_instr_num),
    .commit_areg(commit_areg), .commit_preg(commit_preg),
    .free_valid(free_valid), .free_preg(free_preg),
    .rob_count(rob_count), .rob_empty(rob_empty));

  always #5 CLK = ~CLK;

  // Per-tag payload derived from the tag itself; odd tags write a register.
  function automatic logic [AREG_W-1:0] tagAreg(input int unsigned t);
    logic [31:0] v;
    v = t;
    return v[4:0];
  endfunction

  function automatic logic [PREG_W-1:0] tagPreg(input int unsigned t);
    logic [31:0] v;
    v = t;
    return v[5:0] ^ 6'h2A;
  endfunction

  function automatic logic [PREG_W-1:0] tagOldPreg(input int unsigned t);
    logic [31:0] v;
    v = t;
    return v[5:0] + 6'd1;
  endfunction

  function automatic logic tagRegwr(input int unsigned t);
    logic [31:0] v;
    v = t;
    return v[0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", name, observed, expected, $time);
    end
  endtask

  // One cycle of stimulus, driven just after a rising edge and released after the next one.
  task automatic applyStimulus(input bit dv, input int unsigned dtag,
                               input bit ev, input int unsigned etag,
                               input bit mv, input int unsigned mtag,
                               input bit rv, input int unsigned rtag);
    int idx;
    disp_valid         = dv;
    disp_instr_num     = dtag;
    disp_areg          = tagAreg(dtag);
    disp_preg          = tagPreg(dtag);
    disp_old_preg      = tagOldPreg(dtag);
    disp_regwr         = tagRegwr(dtag);
    exe_complete       = ev;
    exe_instr_num      = etag;
    mem_complete       = mv;
    mem_instr_num      = mtag;
    redirect_valid     = rv;
    redirect_instr_num = rtag;
    #1;
    if (dv) checkOutput("disp_ready", {31'd0, disp_ready}, {31'd0, !expect_drop && !rv});
    if (rv) checkOutput("ready_in_redirect", {31'd0, disp_ready}, 32'd0);
    if (dv && !expect_drop && !rv) exp_q.push_back(dtag);
    if (rv) begin
      idx = -1;
      foreach (exp_q[i]) if (exp_q[i] == rtag) idx = i;
      if (idx >= 0) while (exp_q.size() > idx + 1 + DELAY_SLOT) void'(exp_q.pop_back());
    end
    @(posedge CLK);
    #1;
    disp_valid     = 1'b0;
    exe_complete   = 1'b0;
    mem_complete   = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Retirement monitor: every pulse must match the oldest surviving dispatch.
  always @(negedge CLK) begin
    int unsigned e;
    if (RESET) begin
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_commit", commit_instr_num, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("commit_tag", commit_instr_num, e);
          checkOutput("commit_areg", {27'd0, commit_areg}, {27'd0, tagAreg(e)});
          checkOutput("commit_preg", {26'd0, commit_preg}, {26'd0, tagPreg(e)});
          checkOutput("free_valid", {31'd0, free_valid}, {31'd0, tagRegwr(e)});
          if (tagRegwr(e)) checkOutput("free_preg", {26'd0, free_preg}, {26'd0, tagOldPreg(e)});
        end
      end else begin
        checkOutput("free_without_commit", {31'd0, free_valid}, 32'd0);
      end
    end
  end

  initial begin
    int waited;
    // Reset values
    #2;
    checkOutput("rst_count", {26'd0, rob_count}, 32'd0);
    checkOutput("rst_empty", {31'd0, rob_empty}, 32'd1);
    checkOutput("rst_commit", {31'd0, commit_valid}, 32'd0);
    checkOutput("rst_commit_tag", commit_instr_num, 32'd0);
    checkOutput("rst_free", {31'd0, free_valid}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] in-order retire");
    for (int t = 1; t <= 3; t++) applyStimulus(1, t, 0, 0, 0, 0, 0, 0);
    checkOutput("inorder_count", {26'd0, rob_count}, 32'd3);
    applyStimulus(0, 0, 1, 3, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 0, 0, 0, 0);
    checkOutput("no_early_commit", {31'd0, commit_valid}, 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("latency_pre", {31'd0, commit_valid}, 32'd0);
    idle(1);
    checkOutput("latency_commit", {31'd0, commit_valid}, 32'd1);
    checkOutput("latency_tag", commit_instr_num, 32'd1);
    idle(3);
    checkOutput("inorder_empty", {31'd0, rob_empty}, 32'd1);

    $display("[TB] dual completion");
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 4, 1, 5, 0, 0);
    idle(4);
    checkOutput("dual_empty", {31'd0, rob_empty}, 32'd1);

    $display("[TB] reset mid-run");
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 6, 1, 7, 0, 0);
    RESET = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midrst_count", {26'd0, rob_count}, 32'd0);
    checkOutput("midrst_empty", {31'd0, rob_empty}, 32'd1);
    @(posedge CLK); #1;
    checkOutput("midrst_commit", {31'd0, commit_valid}, 32'd0);
    checkOutput("midrst_free", {31'd0, free_valid}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    idle(3);
    checkOutput("midrst_after", {26'd0, rob_count}, 32'd0);

    $display("[TB] full and wrap");
    for (int t = 1; t <= 32; t++) applyStimulus(1, t, 0, 0, 0, 0, 0, 0);
    checkOutput("full_count", {26'd0, rob_count}, 32'd32);
    checkOutput("full_ready", {31'd0, disp_ready}, 32'd0);
    expect_drop = 1'b1;
    applyStimulus(1, 99, 0, 0, 0, 0, 0, 0);
    expect_drop = 1'b0;
    checkOutput("drop_count", {26'd0, rob_count}, 32'd32);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    checkOutput("after_commit_count", {26'd0, rob_count}, 32'd31);
    applyStimulus(1, 33, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_count", {26'd0, rob_count}, 32'd32);
    for (int t = 2; t <= 33; t++) applyStimulus(0, 0, 1, t, 0, 0, 0, 0);
    idle(3);
    checkOutput("wrap_empty", {31'd0, rob_empty}, 32'd1);

    $display("[TB] redirect");
    for (int t = 10; t <= 15; t++) applyStimulus(1, t, 0, 0, 0, 0, 0, 0);
    checkOutput("redir_pre_count", {26'd0, rob_count}, 32'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 11);
    checkOutput("redir_count", {26'd0, rob_count}, 32'd3);
    applyStimulus(0, 0, 1, 14, 1, 13, 0, 0);
    applyStimulus(1, 16, 0, 0, 0, 0, 0, 0);
    checkOutput("redir_tail_count", {26'd0, rob_count}, 32'd4);
    applyStimulus(0, 0, 1, 10, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 11, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 12, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 16, 0, 0, 0, 0);
    idle(3);
    checkOutput("redir_empty", {31'd0, rob_empty}, 32'd1);

    $display("[TB] collision");
    for (int t = 20; t <= 23; t++) applyStimulus(1, t, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 20, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 22, 1, 23, 1, 21);
    checkOutput("coll_commit", {31'd0, commit_valid}, 32'd1);
    checkOutput("coll_count", {26'd0, rob_count}, 32'd2);
    applyStimulus(0, 0, 1, 21, 0, 0, 0, 0);
    idle(4);
    checkOutput("coll_empty", {31'd0, rob_empty}, 32'd1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      idle(1);
      waited++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
